exp_sequencer: RTL and testbench
================================

Name: exp_sequencer

Overview:
- Upstream feeder for the `exponentiation` unit.
- Accepts a stream of IEEE-754 single-precision operands (vectors delimited by a last flag) into a small FIFO.
- Issues operands one at a time to the exponentiation unit via its start/exp/valid/busy interface.
- Returns each result on a valid/ready output stream with the last flag preserved, and detects a hung unit by timeout.

Parameters:
- DATA_W, 32, operand/result width (IEEE-754 single).
- FIFO_DEPTH, 4, input FIFO entries; power of two, ≥2.
- TIMEOUT, 2048, max cycles spent in WAIT before forcing an error result.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  FIFO can accept; equals !full.
- in_data  in  DATA_W  operand.
- in_last  in  1  operand is last of vector.
- exp_start  out  1  one-cycle start pulse to the exponentiation unit.
- exp_operand  out  DATA_W  operand to the unit (drives its exp port).
- exp_result  in  DATA_W  unit result.
- exp_valid  in  1  unit result valid.
- exp_busy  in  1  unit busy.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  result.
- out_last  out  1  last flag of the corresponding operand.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.
- vec_count  out  16  results delivered in the current vector.
- timeout_err  out  1  sticky; set on any timeout.

Behaviour:
- Reset (rst=1 at a clock edge):
  - FIFO emptied; state IDLE.
  - Outputs: exp_start=0, exp_operand=0, out_valid=0, out_data=0, out_last=0, fifo_count=0, vec_count=0, timeout_err=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation abandons the in-flight operand; a later exp_valid is ignored because the state is IDLE.
- FIFO:
  - Push when in_valid&in_ready; stores {in_last, in_data}.
  - Pop only on the IDLE→ISSUE transition.
  - in_ready = (fifo_count != FIFO_DEPTH), derived from the registered count. No bypass when full, even if a pop occurs the same cycle.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if fifo_count≠0 and exp_busy=0 → ISSUE. Pop the head into exp_operand and the pending-last register.
  - ISSUE: exactly one cycle; exp_start=1. → WAIT; clear the timeout counter.
  - WAIT:
    - exp_start=0.
    - On exp_valid=1: latch exp_result into out_data and pending-last into out_last; set out_valid=1; → HOLD.
    - Otherwise increment the counter. When it reaches TIMEOUT-1: out_data=32'h7FC00000 (quiet NaN), out_last=pending-last, out_valid=1, timeout_err=1; → HOLD.
  - HOLD:
    - out_valid=1; out_data and out_last stable until out_valid&out_ready.
    - On handshake: out_valid=0; → IDLE.
- exp_operand holds its value from ISSUE through WAIT and HOLD, and changes only on the next pop.
- exp_valid outside WAIT is ignored.
- Only one operand is in flight at a time.
- Latency:
  - Operand accepted at edge t with an empty FIFO and idle unit: exp_start is high during the cycle after edge t+1.
  - exp_valid sampled at edge u: out_valid is high from edge u.
  - IDLE can re-issue the next operand no earlier than the edge after the output handshake.
- vec_count:
  - +1 on each output handshake; saturates at 16'hFFFF.
  - Cleared to 0 on a handshake with out_last=1.
- timeout_err clears only on rst.

Test Plan:
- Single operand: push 32'h40A00000 (5.0, last=1); stub unit returns operand+1 after 20 cycles → exactly one exp_start pulse with exp_operand=32'h40A00000; out_data=32'h40A00001, out_last=1, vec_count returns to 0.
- Back-to-back vector: push 5.0, 3.0 (32'h40400000), 1.0 (32'h3F800000, last=1) continuously → three starts, strictly serialized; results in order, with out_last only on the third.
- Full FIFO/backpressure: out_ready=0, push 6 operands → in_ready drops once fifo_count=4 (one operand already issued); no data lost; all results in order after out_ready=1.
- Busy gating: hold exp_busy=1 with a non-empty FIFO → no exp_start; release → start within 2 cycles.
- Timeout: stub never asserts exp_valid → after TIMEOUT cycles in WAIT, out_data=32'h7FC00000, timeout_err=1; the next operand still processes normally.
- Reset mid-operation: assert rst during WAIT with 2 entries queued → all outputs at reset values; a late exp_valid produces no output.

Source files
------------

// File: rtl/exp_sequencer.sv
// exp_sequencer: feeds IEEE-754 single operands from a small FIFO to an
// exponentiation unit one at a time and returns each result on a
// valid/ready stream, carrying the vector's last flag alongside.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_last     operand input stream
//   exp_start/exp_operand       start pulse and operand to the unit
//   exp_result/exp_valid/exp_busy         result and status from the unit
//   out_valid/out_ready/out_data/out_last result output stream
//   fifo_count                  occupied FIFO entries
//   vec_count                   results delivered in the current vector
//   timeout_err                 sticky flag, set when the unit never answers
module exp_sequencer #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 2048
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_W-1:0]               in_data,
  input  logic                            in_last,
  output logic                            exp_start,
  output logic [DATA_W-1:0]               exp_operand,
  input  logic [DATA_W-1:0]               exp_result,
  input  logic                            exp_valid,
  input  logic                            exp_busy,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_W-1:0]               out_data,
  output logic                            out_last,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic [15:0]                     vec_count,
  output logic                            timeout_err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] QNAN = DATA_W'(32'h7FC0_0000);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

  state_e                state;
  logic [DATA_W:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [TO_W-1:0]       to_cnt;
  logic                  pend_last;
  logic                  push;
  logic                  pop;

  // in_ready comes from the registered count only: a full FIFO refuses
  // data even in a cycle where an entry is being popped.
  assign in_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = (state == StIdle) && (fifo_count != '0) && !exp_busy;

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_last, in_data};
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      exp_start   <= 1'b0;
      exp_operand <= '0;
      pend_last   <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      vec_count   <= '0;
      timeout_err <= 1'b0;
      to_cnt      <= '0;
    end else begin
      exp_start <= 1'b0;
      case (state)
        StIdle: begin
          if (pop) begin
            {pend_last, exp_operand} <= mem[rd_ptr];
            exp_start                <= 1'b1;
            state                    <= StIssue;
          end
        end
        StIssue: begin
          to_cnt <= '0;
          state  <= StWait;
        end
        StWait: begin
          if (exp_valid) begin
            out_data  <= exp_result;
            out_last  <= pend_last;
            out_valid <= 1'b1;
            state     <= StHold;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            // Unit never answered: emit a quiet NaN so the stream keeps moving.
            out_data    <= QNAN;
            out_last    <= pend_last;
            out_valid   <= 1'b1;
            timeout_err <= 1'b1;
            state       <= StHold;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        StHold: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= StIdle;
            if (out_last) begin
              vec_count <= '0;
            end else if (vec_count != 16'hFFFF) begin
              vec_count <= vec_count + 1'b1;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_sequencer.sv
// Testbench for exp_sequencer: a stub exponentiation unit answers with
// operand+1 after a programmable latency; a queue-based scoreboard predicts
// issued operands and delivered results, including timeout NaNs.
module tb_exp_sequencer;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned TIMEOUT    = 64;
  localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] NAN        = 32'h7FC0_0000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_data = '0;
  logic              in_last = 1'b0;
  logic              exp_start;
  logic [31:0]       exp_operand;
  logic [31:0]       exp_result = '0;
  logic              exp_valid = 1'b0;
  logic              exp_busy;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic              out_last;
  logic [CW-1:0]     fifo_count;
  logic [15:0]       vec_count;
  logic              timeout_err;

  logic force_busy = 1'b0;
  logic stub_busy  = 1'b0;
  logic base_ready = 1'b1;
  logic rnd_ready  = 1'b1;
  logic rand_rdy   = 1'b0;

  assign exp_busy  = force_busy | stub_busy;
  assign out_ready = rand_rdy ? rnd_ready : base_ready;

  int total = 0;
  int bad   = 0;

  logic [31:0] issue_q[$];
  logic [32:0] out_q[$];
  int          starts    = 0;
  int          outs      = 0;
  logic        in_flight = 1'b0;
  int unsigned vec_model = 0;

  logic        stub_on  = 1'b1;
  int          stub_lat = 4;
  int          stub_cnt = 0;
  logic [31:0] stub_op  = '0;

  exp_sequencer #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .exp_start  (exp_start),
    .exp_operand(exp_operand),
    .exp_result (exp_result),
    .exp_valid  (exp_valid),
    .exp_busy   (exp_busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .fifo_count (fifo_count),
    .vec_count  (vec_count),
    .timeout_err(timeout_err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Stub unit: latches the operand on a start pulse, answers stub_lat cycles later.
  initial begin
    forever begin
      @(posedge clk); #1;
      exp_valid = 1'b0;
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          exp_valid  = 1'b1;
          exp_result = stub_op + 32'd1;
          stub_busy  = 1'b0;
        end
      end else if (exp_start === 1'b1 && stub_on) begin
        stub_op   = exp_operand;
        stub_cnt  = stub_lat;
        stub_busy = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      rnd_ready = 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard: issued operands and delivered results, checked mid-cycle.
  always @(negedge clk) begin
    logic [32:0] e;
    if (exp_start === 1'b1) begin
      starts++;
      chk("serialized", {63'b0, in_flight}, 64'd0);
      in_flight = 1'b1;
      chk("start_pending", {63'b0, issue_q.size() != 0}, 64'd1);
      if (issue_q.size() != 0) chk("exp_operand", exp_operand, issue_q.pop_front());
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      outs++;
      chk("out_pending", {63'b0, out_q.size() != 0}, 64'd1);
      if (out_q.size() != 0) begin
        e = out_q.pop_front();
        chk("out_data", out_data, e[31:0]);
        chk("out_last", out_last, e[32]);
      end
      chk("vec_count", vec_count, vec_model);
      if (out_last === 1'b1) vec_model = 0;
      else if (vec_model != 16'hFFFF) vec_model++;
      in_flight = 1'b0;
    end
  end

  task automatic push(input logic [31:0] d, input logic l);
    int guard = 0;
    issue_q.push_back(d);
    out_q.push_back({l, (stub_on ? d + 32'd1 : NAN)});
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("push_accept", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while ((out_q.size() != 0 || in_flight) && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk(tag, out_q.size(), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_exp_start"}, exp_start, 0);
    chk({tag, "_exp_operand"}, exp_operand, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_fifo_count"}, fifo_count, 0);
    chk({tag, "_vec_count"}, vec_count, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    int s0;
    int o0;
    int cyc;
    int g;
    logic seen;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_values("rst");

    // Single operand with latency checks
    base_ready = 1'b1;
    stub_lat   = 20;
    push(32'h40A0_0000, 1'b1);
    chk("lat_pre_start", exp_start, 0);
    @(posedge clk); #1;
    chk("lat_start", exp_start, 1);
    chk("lat_operand", exp_operand, 32'h40A0_0000);
    g = 0;
    @(negedge clk);
    while (exp_valid !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk); #1;
    chk("lat_out_valid", out_valid, 1);
    drain("single_drain");
    chk("single_starts", starts, 1);
    chk("single_vec", vec_count, 0);
    chk("single_idle_out_valid", out_valid, 0);

    // Back-to-back vector
    stub_lat = int'($urandom_range(1, 8));
    push(32'h40A0_0000, 1'b0);
    push(32'h4040_0000, 1'b0);
    push(32'h3F80_0000, 1'b1);
    drain("vector_drain");
    chk("vector_starts", starts, 4);
    chk("vector_outs", outs, 4);

    // Full FIFO / backpressure
    base_ready = 1'b0;
    stub_lat   = 2;
    o0 = outs;
    for (int i = 0; i < 5; i++) push($urandom, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("full_count", fifo_count, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    fork
      push($urandom, 1'b1);
      begin
        repeat (6) @(posedge clk);
        #1 base_ready = 1'b1;
      end
    join
    drain("full_drain");
    chk("full_outs", outs - o0, 6);

    // Randomized traffic with random backpressure and latency
    rand_rdy = 1'b1;
    for (int i = 0; i < 24; i++) begin
      stub_lat = int'($urandom_range(1, 6));
      push($urandom, (i == 23) ? 1'b1 : 1'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain("rand_drain");
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    chk("rand_vec", vec_count, 0);

    // Busy gating
    force_busy = 1'b1;
    stub_lat   = 3;
    s0 = starts;
    push(32'h4100_0000, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk("busy_no_start", starts, s0);
    chk("busy_count", fifo_count, 1);
    force_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("busy_release_start", starts, s0 + 1);
    drain("busy_drain");

    // Timeout
    stub_on = 1'b0;
    push(32'h4120_0000, 1'b1);
    g = 0;
    while (exp_start !== 1'b1 && g < 10) begin
      @(posedge clk); #1;
      g++;
    end
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < int'(TIMEOUT) + 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("timeout_cycles", cyc, TIMEOUT + 1);
    chk("timeout_data", out_data, NAN);
    chk("timeout_err", timeout_err, 1);
    drain("timeout_drain");
    stub_on  = 1'b1;
    stub_lat = 5;
    push(32'h3FC0_0000, 1'b1);
    drain("post_timeout_drain");
    chk("timeout_sticky", timeout_err, 1);

    // Reset mid-operation with two entries queued
    stub_lat = 40;
    push(32'h4000_0000, 1'b0);
    push(32'h4080_0000, 1'b0);
    push(32'h40C0_0000, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_queued", fifo_count, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    issue_q.delete();
    out_q.delete();
    in_flight = 1'b0;
    vec_model = 0;
    chk_reset_values("midrst");
    s0   = starts;
    o0   = outs;
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk("midrst_late_valid_ignored", seen, 0);
    chk("midrst_no_start", starts, s0);
    chk("midrst_no_out", outs, o0);

    // Recovery after reset
    stub_lat = 3;
    push(32'h4110_0000, 1'b1);
    drain("recover_drain");
    chk("recover_outs", outs, o0 + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
